raptor64_xfeed: RTL and testbench
=================================

Name: raptor64_xfeed

Overview:
- Execute-stage operand feed register for the Raptor64 pipeline.
- Sits between register-file/decode and the execute datapath (set-compare unit, ALU).
- Captures the decoded instruction word, operands and immediate, and resolves operand bypass from the X, M and W stages.
- Detects load-use hazards, injects bubbles, and honours downstream stall and pipeline flush.

Parameters:
- NOP_IR, 42'd0: instruction word loaded into x_ir_o on a bubble or flush.
- HCNT_W, 16: width of the saturating load-use bubble counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- d_valid_i  in  1  decode slot holds a real instruction.
- d_ir_i  in  42  decoded instruction word; opcode in [41:35], func in [6:0].
- d_ra_i  in  6  source register A number.
- d_rb_i  in  6  source register B number.
- d_rt_i  in  6  target register number (0 = no write).
- d_is_load_i  in  1  decode instruction is a memory load.
- rf_a_i  in  64  register file read port A.
- rf_b_i  in  64  register file read port B.
- d_imm_i  in  64  sign/zero-extended immediate.
- x_res_i  in  64  result the execute stage produces this cycle for the instruction in x_*_o.
- m_valid_i  in  1  M-stage instruction writes a register.
- m_rt_i  in  6  M-stage target register.
- m_res_i  in  64  M-stage result.
- w_valid_i  in  1  W-stage instruction writes a register.
- w_rt_i  in  6  W-stage target register.
- w_res_i  in  64  W-stage result.
- stall_i  in  1  downstream stall; hold the X stage.
- flush_i  in  1  kill the X-stage contents (branch mispredict or exception).
- d_ready_o  out  1  decode may advance this cycle.
- x_valid_o  out  1  X stage holds a real instruction.
- x_ir_o  out  42  registered instruction word.
- x_a_o  out  64  registered operand A.
- x_b_o  out  64  registered operand B.
- x_imm_o  out  64  registered immediate.
- x_rt_o  out  6  registered target register.
- x_is_load_o  out  1  registered load flag.
- hcnt_o  out  HCNT_W  saturating count of load-use bubbles inserted.

Behaviour:
Reset (rst_i low, asynchronous):
- x_valid_o=0, x_ir_o=NOP_IR.
- x_a_o, x_b_o, x_imm_o = 0.
- x_rt_o=0, x_is_load_o=0, hcnt_o=0.
- Reset asserted mid-stall or mid-bubble discards all state immediately.

Bypass mux (combinational, per operand, shown for A; B is identical using d_rb_i/rf_b_i):
- d_ra_i==0 gives 0, regardless of rf_a_i or any bypass.
- else if x_valid_o && !x_is_load_o && x_rt_o==d_ra_i: x_res_i.
- else if m_valid_i && m_rt_i==d_ra_i: m_res_i.
- else if w_valid_i && w_rt_i==d_ra_i: w_res_i.
- else rf_a_i.
- Priority is strictly X > M > W.

Hazard (combinational):
- hazard = d_valid_i && x_valid_o && x_is_load_o && x_rt_o!=0 && (x_rt_o==d_ra_i || x_rt_o==d_rb_i).
- d_ready_o = !stall_i && !hazard. flush_i does not affect d_ready_o.

Clocked update (priority order, first match wins):
1. flush_i: x_valid_o←0, x_ir_o←NOP_IR, x_rt_o←0, x_is_load_o←0. Flush wins over stall_i and hazard; hcnt_o is not incremented.
2. stall_i: all x_* outputs hold. Operands were bypassed at capture, so later M/W changes do not alter held values.
3. hazard: bubble. x_valid_o←0, x_ir_o←NOP_IR, x_rt_o←0, x_is_load_o←0. hcnt_o increments, saturating at all-ones. The decode instruction is retried next cycle, when the load is in M and is satisfied by M bypass.
4. Otherwise: capture.
   - x_valid_o←d_valid_i, x_ir_o←d_ir_i.
   - x_a_o/x_b_o←bypassed values, x_imm_o←d_imm_i.
   - x_rt_o←d_rt_i, x_is_load_o←d_is_load_i.
   - When d_valid_i=0, capture x_ir_o←NOP_IR and x_rt_o←0.

Timing:
- Latency is one cycle from decode to X outputs.
- No combinational path from x_res_i to any output other than through the registered x_a_o/x_b_o.

Test Plan:
- Reset/idle: hold rst_i low, then release. Require all outputs at reset values, x_ir_o=0 and d_ready_o=1. Assert rst_i low during stall_i=1 and require immediate clear.
- Bypass priority: x_rt=5 non-load with x_res=64'hA, m_rt=5 with m_res=64'hB, w_rt=5 with w_res=64'hC, decode reads ra=5. Next cycle require x_a_o=64'hA. Remove the X match and require 64'hB; remove the M match and require 64'hC.
- R0 immunity: d_ra_i=0 with rf_a_i=64'hFFFF and m_rt_i=0 asserted. Require x_a_o=0.
- Load-use: load to r7 in X, decode reads rb=7. Require d_ready_o=0, one bubble (x_valid_o=0, x_ir_o=NOP_IR) and hcnt_o=1. Next cycle, with m_rt=7 and m_res=64'h1234, require capture with x_b_o=64'h1234.
- Stall: load valid op, then stall_i=1 for 3 cycles while changing all decode and bypass inputs. Require x_* outputs unchanged and d_ready_o=0. On release, require capture of the current decode.
- Flush vs stall and hazard: flush_i=1 together with stall_i=1 and a pending hazard. Require x_valid_o=0, x_ir_o=NOP_IR and hcnt_o unchanged. Separately, force HCNT_W=2 and insert 5 bubbles; require hcnt_o to saturate at 3.

Source files
------------

// File: rtl/raptor64_xfeed_if.sv
// Decode-to-execute operand feed bundle: decode/bypass/control inputs toward the X register,
// registered X-stage outputs back out.
interface raptor64_xfeed_if #(
  parameter int unsigned HCNT_W = 16
);
  logic              d_valid_i;
  logic [41:0]       d_ir_i;
  logic [5:0]        d_ra_i;
  logic [5:0]        d_rb_i;
  logic [5:0]        d_rt_i;
  logic              d_is_load_i;
  logic [63:0]       rf_a_i;
  logic [63:0]       rf_b_i;
  logic [63:0]       d_imm_i;
  logic [63:0]       x_res_i;
  logic              m_valid_i;
  logic [5:0]        m_rt_i;
  logic [63:0]       m_res_i;
  logic              w_valid_i;
  logic [5:0]        w_rt_i;
  logic [63:0]       w_res_i;
  logic              stall_i;
  logic              flush_i;
  logic              d_ready_o;
  logic              x_valid_o;
  logic [41:0]       x_ir_o;
  logic [63:0]       x_a_o;
  logic [63:0]       x_b_o;
  logic [63:0]       x_imm_o;
  logic [5:0]        x_rt_o;
  logic              x_is_load_o;
  logic [HCNT_W-1:0] hcnt_o;

  modport master (
    output d_valid_i, d_ir_i, d_ra_i, d_rb_i, d_rt_i, d_is_load_i,
    output rf_a_i, rf_b_i, d_imm_i, x_res_i,
    output m_valid_i, m_rt_i, m_res_i, w_valid_i, w_rt_i, w_res_i,
    output stall_i, flush_i,
    input  d_ready_o, x_valid_o, x_ir_o, x_a_o, x_b_o, x_imm_o, x_rt_o, x_is_load_o, hcnt_o
  );

  modport slave (
    input  d_valid_i, d_ir_i, d_ra_i, d_rb_i, d_rt_i, d_is_load_i,
    input  rf_a_i, rf_b_i, d_imm_i, x_res_i,
    input  m_valid_i, m_rt_i, m_res_i, w_valid_i, w_rt_i, w_res_i,
    input  stall_i, flush_i,
    output d_ready_o, x_valid_o, x_ir_o, x_a_o, x_b_o, x_imm_o, x_rt_o, x_is_load_o, hcnt_o
  );
endinterface

// File: rtl/raptor64_xfeed.sv
// Raptor64 execute-stage operand feed: captures decode, resolves X/M/W bypass, inserts
// load-use bubbles and honours stall/flush.
module raptor64_xfeed #(
  parameter logic [41:0] NOP_IR = 42'd0,
  parameter int unsigned HCNT_W = 16
) (
  input logic            clk_i,
  input logic            rst_i,
  raptor64_xfeed_if.slave bus
);

  logic              r_x_valid;
  logic [41:0]       r_x_ir;
  logic [63:0]       r_x_a;
  logic [63:0]       r_x_b;
  logic [63:0]       r_x_imm;
  logic [5:0]        r_x_rt;
  logic              r_x_is_load;
  logic [HCNT_W-1:0] r_hcnt;

  logic              w_x_valid_nxt;
  logic [41:0]       w_x_ir_nxt;
  logic [63:0]       w_x_a_nxt;
  logic [63:0]       w_x_b_nxt;
  logic [63:0]       w_x_imm_nxt;
  logic [5:0]        w_x_rt_nxt;
  logic              w_x_is_load_nxt;
  logic [HCNT_W-1:0] w_hcnt_nxt;

  logic              w_x_fwd_ok;
  logic              w_hazard;
  logic [63:0]       w_byp_a;
  logic [63:0]       w_byp_b;

  // A load in X has no result yet, so it can never forward from X.
  function automatic logic [63:0] bypass(
    input logic [5:0]  rs,
    input logic [63:0] rf,
    input logic        x_ok,
    input logic [5:0]  x_rt,
    input logic [63:0] x_res,
    input logic        m_v,
    input logic [5:0]  m_rt,
    input logic [63:0] m_res,
    input logic        w_v,
    input logic [5:0]  w_rt,
    input logic [63:0] w_res
  );
    if (rs == 6'd0)                 return 64'd0;
    else if (x_ok && x_rt == rs)    return x_res;
    else if (m_v && m_rt == rs)     return m_res;
    else if (w_v && w_rt == rs)     return w_res;
    else                            return rf;
  endfunction

  assign w_x_fwd_ok = r_x_valid && !r_x_is_load;

  assign w_byp_a = bypass(bus.d_ra_i, bus.rf_a_i, w_x_fwd_ok, r_x_rt, bus.x_res_i,
                          bus.m_valid_i, bus.m_rt_i, bus.m_res_i,
                          bus.w_valid_i, bus.w_rt_i, bus.w_res_i);
  assign w_byp_b = bypass(bus.d_rb_i, bus.rf_b_i, w_x_fwd_ok, r_x_rt, bus.x_res_i,
                          bus.m_valid_i, bus.m_rt_i, bus.m_res_i,
                          bus.w_valid_i, bus.w_rt_i, bus.w_res_i);

  assign w_hazard = bus.d_valid_i && r_x_valid && r_x_is_load && (r_x_rt != 6'd0) &&
                    ((r_x_rt == bus.d_ra_i) || (r_x_rt == bus.d_rb_i));

  assign bus.d_ready_o = !bus.stall_i && !w_hazard;

  always_comb begin
    w_x_valid_nxt   = r_x_valid;
    w_x_ir_nxt      = r_x_ir;
    w_x_a_nxt       = r_x_a;
    w_x_b_nxt       = r_x_b;
    w_x_imm_nxt     = r_x_imm;
    w_x_rt_nxt      = r_x_rt;
    w_x_is_load_nxt = r_x_is_load;
    w_hcnt_nxt      = r_hcnt;
    if (bus.flush_i) begin
      w_x_valid_nxt   = 1'b0;
      w_x_ir_nxt      = NOP_IR;
      w_x_rt_nxt      = 6'd0;
      w_x_is_load_nxt = 1'b0;
    end else if (bus.stall_i) begin
      // Hold: operands were already bypassed at capture time.
    end else if (w_hazard) begin
      w_x_valid_nxt   = 1'b0;
      w_x_ir_nxt      = NOP_IR;
      w_x_rt_nxt      = 6'd0;
      w_x_is_load_nxt = 1'b0;
      if (r_hcnt != {HCNT_W{1'b1}}) begin
        w_hcnt_nxt = r_hcnt + {{(HCNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      w_x_valid_nxt   = bus.d_valid_i;
      w_x_ir_nxt      = bus.d_valid_i ? bus.d_ir_i : NOP_IR;
      w_x_a_nxt       = w_byp_a;
      w_x_b_nxt       = w_byp_b;
      w_x_imm_nxt     = bus.d_imm_i;
      w_x_rt_nxt      = bus.d_valid_i ? bus.d_rt_i : 6'd0;
      w_x_is_load_nxt = bus.d_is_load_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_x_valid   <= 1'b0;
      r_x_ir      <= NOP_IR;
      r_x_a       <= 64'd0;
      r_x_b       <= 64'd0;
      r_x_imm     <= 64'd0;
      r_x_rt      <= 6'd0;
      r_x_is_load <= 1'b0;
      r_hcnt      <= '0;
    end else begin
      r_x_valid   <= w_x_valid_nxt;
      r_x_ir      <= w_x_ir_nxt;
      r_x_a       <= w_x_a_nxt;
      r_x_b       <= w_x_b_nxt;
      r_x_imm     <= w_x_imm_nxt;
      r_x_rt      <= w_x_rt_nxt;
      r_x_is_load <= w_x_is_load_nxt;
      r_hcnt      <= w_hcnt_nxt;
    end
  end

  assign bus.x_valid_o   = r_x_valid;
  assign bus.x_ir_o      = r_x_ir;
  assign bus.x_a_o       = r_x_a;
  assign bus.x_b_o       = r_x_b;
  assign bus.x_imm_o     = r_x_imm;
  assign bus.x_rt_o      = r_x_rt;
  assign bus.x_is_load_o = r_x_is_load;
  assign bus.hcnt_o      = r_hcnt;

endmodule

// File: tb/tb_raptor64_xfeed.sv
// Scoreboard bench for raptor64_xfeed: expected X-stage state is queued as each decode cycle
// is driven and compared one clock later.
module tb_raptor64_xfeed;

  typedef struct {
    string       tag;
    logic        v;
    logic [41:0] ir;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] imm;
    logic [5:0]  rt;
    logic        ld;
    logic [15:0] hc;
  } exp_t;

  typedef struct {
    string      tag;
    logic       v;
    logic [1:0] hc;
  } sat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  exp_t sb0[$];
  sat_t sb1[$];
  exp_t cur;
  exp_t mon_e;
  sat_t mon_s;

  always #5 clk = ~clk;

  raptor64_xfeed_if #(.HCNT_W(16)) b0 ();
  raptor64_xfeed_if #(.HCNT_W(2))  b1 ();

  raptor64_xfeed #(.NOP_IR(42'd0), .HCNT_W(16)) u_dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (b0)
  );

  raptor64_xfeed #(.NOP_IR(42'd0), .HCNT_W(2)) u_sat (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (b1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".v"},   b0.x_valid_o,   0);
    check({tag, ".ir"},  b0.x_ir_o,      0);
    check({tag, ".a"},   b0.x_a_o,       0);
    check({tag, ".b"},   b0.x_b_o,       0);
    check({tag, ".imm"}, b0.x_imm_o,     0);
    check({tag, ".rt"},  b0.x_rt_o,      0);
    check({tag, ".ld"},  b0.x_is_load_o, 0);
    check({tag, ".hc"},  b0.hcnt_o,      0);
  endtask

  task automatic idle_inputs();
    b0.d_valid_i = 0; b0.d_ir_i = '0; b0.d_ra_i = '0; b0.d_rb_i = '0; b0.d_rt_i = '0;
    b0.d_is_load_i = 0; b0.rf_a_i = '0; b0.rf_b_i = '0; b0.d_imm_i = '0; b0.x_res_i = '0;
    b0.m_valid_i = 0; b0.m_rt_i = '0; b0.m_res_i = '0;
    b0.w_valid_i = 0; b0.w_rt_i = '0; b0.w_res_i = '0;
    b0.stall_i = 0; b0.flush_i = 0;
    b1.d_valid_i = 0; b1.d_ir_i = '0; b1.d_ra_i = '0; b1.d_rb_i = '0; b1.d_rt_i = '0;
    b1.d_is_load_i = 0; b1.rf_a_i = '0; b1.rf_b_i = '0; b1.d_imm_i = '0; b1.x_res_i = '0;
    b1.m_valid_i = 0; b1.m_rt_i = '0; b1.m_res_i = '0;
    b1.w_valid_i = 0; b1.w_rt_i = '0; b1.w_res_i = '0;
    b1.stall_i = 0; b1.flush_i = 0;
  endtask

  task automatic decode(input logic v, input logic [41:0] ir, input logic [5:0] ra,
                        input logic [5:0] rb, input logic [5:0] rt, input logic ld,
                        input logic [63:0] rfa, input logic [63:0] rfb, input logic [63:0] imm);
    b0.d_valid_i = v; b0.d_ir_i = ir; b0.d_ra_i = ra; b0.d_rb_i = rb; b0.d_rt_i = rt;
    b0.d_is_load_i = ld; b0.rf_a_i = rfa; b0.rf_b_i = rfb; b0.d_imm_i = imm;
  endtask

  // Push the current expectation, then advance to the next drive point.
  task automatic step(input string tag, input logic ready_exp);
    #1;
    check({tag, ".rdy"}, b0.d_ready_o, ready_exp);
    cur.tag = tag;
    sb0.push_back(cur);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb0.size() != 0) begin
      mon_e = sb0.pop_front();
      check({mon_e.tag, ".v"},   b0.x_valid_o,   mon_e.v);
      check({mon_e.tag, ".ir"},  b0.x_ir_o,      mon_e.ir);
      check({mon_e.tag, ".a"},   b0.x_a_o,       mon_e.a);
      check({mon_e.tag, ".b"},   b0.x_b_o,       mon_e.b);
      check({mon_e.tag, ".imm"}, b0.x_imm_o,     mon_e.imm);
      check({mon_e.tag, ".rt"},  b0.x_rt_o,      mon_e.rt);
      check({mon_e.tag, ".ld"},  b0.x_is_load_o, mon_e.ld);
      check({mon_e.tag, ".hc"},  b0.hcnt_o,      mon_e.hc);
    end
    if (sb1.size() != 0) begin
      mon_s = sb1.pop_front();
      check({mon_s.tag, ".v"},  b1.x_valid_o, mon_s.v);
      check({mon_s.tag, ".hc"}, b1.hcnt_o,    mon_s.hc);
    end
  end

  initial begin
    int bubbles;
    idle_inputs();
    cur = '{tag: "", v: 0, ir: 0, a: 0, b: 0, imm: 0, rt: 0, ld: 0, hc: 0};
    repeat (3) @(negedge clk);
    check_reset("reset");
    check("reset.rdy", b0.d_ready_o, 1);
    rst_n = 1'b1;

    // Bypass priority X > M > W.
    decode(1, 42'h0AA_0000_0001, 6'd1, 6'd2, 6'd5, 0, 64'd11, 64'd22, 64'd7);
    cur.v = 1; cur.ir = 42'h0AA_0000_0001; cur.a = 11; cur.b = 22; cur.imm = 7;
    cur.rt = 5; cur.ld = 0;
    step("cap1", 1);

    decode(1, 42'h0AA_0000_0002, 6'd5, 6'd0, 6'd6, 0, 64'h55, 64'h66, 64'd8);
    b0.x_res_i = 64'hA;
    b0.m_valid_i = 1; b0.m_rt_i = 6'd5; b0.m_res_i = 64'hB;
    b0.w_valid_i = 1; b0.w_rt_i = 6'd5; b0.w_res_i = 64'hC;
    cur.ir = 42'h0AA_0000_0002; cur.a = 64'hA; cur.b = 0; cur.imm = 8; cur.rt = 6;
    step("byp_x", 1);

    decode(1, 42'h0AA_0000_0003, 6'd5, 6'd0, 6'd6, 0, 64'h55, 64'h66, 64'd9);
    cur.ir = 42'h0AA_0000_0003; cur.a = 64'hB; cur.imm = 9;
    step("byp_m", 1);

    decode(1, 42'h0AA_0000_0004, 6'd5, 6'd5, 6'd6, 0, 64'h55, 64'h66, 64'd10);
    b0.m_valid_i = 0;
    cur.ir = 42'h0AA_0000_0004; cur.a = 64'hC; cur.b = 64'hC; cur.imm = 10;
    step("byp_w", 1);

    // Register 0 reads as zero even when M claims to write it.
    decode(1, 42'h0AA_0000_0005, 6'd0, 6'd3, 6'd0, 0, 64'hFFFF, 64'h33, 64'd0);
    b0.w_valid_i = 0;
    b0.m_valid_i = 1; b0.m_rt_i = 6'd0; b0.m_res_i = 64'h99;
    cur.ir = 42'h0AA_0000_0005; cur.a = 0; cur.b = 64'h33; cur.imm = 0; cur.rt = 0;
    step("r0", 1);

    // Load-use: one bubble, then retry satisfied from M.
    b0.m_valid_i = 0;
    decode(1, 42'h155_0000_0007, 6'd0, 6'd0, 6'd7, 1, 64'h1, 64'h2, 64'h40);
    cur.ir = 42'h155_0000_0007; cur.a = 0; cur.b = 0; cur.imm = 64'h40; cur.rt = 7; cur.ld = 1;
    step("ld_cap", 1);

    decode(1, 42'h0BB_0000_0001, 6'd1, 6'd7, 6'd8, 0, 64'h10, 64'hDEAD, 64'h50);
    cur.v = 0; cur.ir = 0; cur.rt = 0; cur.ld = 0; cur.hc = 1;
    step("ld_bubble", 0);

    b0.m_valid_i = 1; b0.m_rt_i = 6'd7; b0.m_res_i = 64'h1234;
    cur.v = 1; cur.ir = 42'h0BB_0000_0001; cur.a = 64'h10; cur.b = 64'h1234;
    cur.imm = 64'h50; cur.rt = 8;
    step("ld_retry", 1);

    // Stall: scramble every decode/bypass input; X must hold.
    b0.stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      decode(1, {10'($urandom()), $urandom()}, 6'($urandom()), 6'($urandom()),
             6'($urandom()), 1'($urandom()), {$urandom(), $urandom()},
             {$urandom(), $urandom()}, {$urandom(), $urandom()});
      b0.x_res_i = {$urandom(), $urandom()};
      b0.m_valid_i = 1; b0.m_rt_i = 6'($urandom()); b0.m_res_i = {$urandom(), $urandom()};
      b0.w_valid_i = 1; b0.w_rt_i = 6'($urandom()); b0.w_res_i = {$urandom(), $urandom()};
      step("stall", 0);
    end

    b0.stall_i = 0; b0.m_valid_i = 0; b0.w_valid_i = 0;
    decode(1, 42'h0CC_0000_0006, 6'd2, 6'd3, 6'd4, 0, 64'h222, 64'h333, 64'h60);
    cur.ir = 42'h0CC_0000_0006; cur.a = 64'h222; cur.b = 64'h333; cur.imm = 64'h60; cur.rt = 4;
    step("stall_rel", 1);

    // Flush beats stall and a pending load-use hazard; no bubble counted.
    decode(1, 42'h155_0000_0009, 6'd0, 6'd0, 6'd9, 1, 64'h0, 64'h0, 64'h70);
    cur.ir = 42'h155_0000_0009; cur.a = 0; cur.b = 0; cur.imm = 64'h70; cur.rt = 9; cur.ld = 1;
    step("ld9_cap", 1);

    decode(1, 42'h0DD_0000_0007, 6'd0, 6'd9, 6'd3, 0, 64'h0, 64'h999, 64'h80);
    b0.flush_i = 1; b0.stall_i = 1;
    cur.v = 0; cur.ir = 0; cur.rt = 0; cur.ld = 0;
    step("flush", 0);

    b0.flush_i = 0; b0.stall_i = 0;
    cur.v = 1; cur.ir = 42'h0DD_0000_0007; cur.b = 64'h999; cur.imm = 64'h80; cur.rt = 3;
    step("post_flush", 1);

    // Invalid decode captures as NOP with no target.
    decode(0, 42'h0EE_0000_0008, 6'd1, 6'd0, 6'd5, 0, 64'h11, 64'h0, 64'h90);
    cur.v = 0; cur.ir = 0; cur.a = 64'h11; cur.b = 0; cur.imm = 64'h90; cur.rt = 0;
    step("inval", 1);

    decode(1, 42'h0FF_0000_0009, 6'd1, 6'd2, 6'd2, 0, 64'h5, 64'h6, 64'hA0);
    cur.v = 1; cur.ir = 42'h0FF_0000_0009; cur.a = 5; cur.b = 6; cur.imm = 64'hA0; cur.rt = 2;
    step("pre_rst", 1);

    // Asynchronous reset during a stall clears without a clock edge.
    b0.stall_i = 1;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("rst_stall");
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;

    // Saturation on the 2-bit counter: constant load r7 <- [r7] alternates capture/bubble.
    b1.d_valid_i = 1; b1.d_is_load_i = 1; b1.d_rt_i = 6'd7; b1.d_ra_i = 6'd7;
    b1.d_ir_i = 42'h111_0000_0001;
    bubbles = 0;
    for (int i = 0; i < 10; i++) begin
      sat_t s;
      if (i % 2 == 1) bubbles++;
      s.tag = (i % 2 == 1) ? "sat_bubble" : "sat_cap";
      s.v = (i % 2 == 0);
      s.hc = (bubbles > 3) ? 2'd3 : 2'(bubbles);
      sb1.push_back(s);
      @(negedge clk);
    end

    repeat (2) @(negedge clk);
    check("sb0_drain", sb0.size(), 0);
    check("sb1_drain", sb1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
